segasys1_sndlatch: RTL and testbench

Sound-command bridge between the main CPU and the sound CPU. It captures each byte the main CPU writes to the sound port (on `SNDRQ`) into a small FIFO and presents it to the sound CPU as a latch. It edge-signals each pending command with an NMI and generates the sound CPU's periodic timer IRQ. It sits directly downstream of the main CPU block, consuming its `SNDRQ`/`CPUDO`, and upstream of the sound CPU's data selector.

---
 rtl/segasys1_sndlatch_pkg.sv | 21 ++
 rtl/segasys1_cmdfifo.sv | 67 ++++++
 rtl/segasys1_sndlatch.sv | 142 ++++++++++++++
 tb/tb_segasys1_sndlatch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/segasys1_sndlatch_pkg.sv
// Shared types and defaults for the Sega System 1 sound-command bridge.
// NMI handshake state encodings are fixed so that debug captures decode consistently.
package segasys1_sndlatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } nmiState_e;

    localparam int DEFAULT_DEPTH      = 4;
    localparam int DEFAULT_IRQ_PERIOD = 200000;
    localparam int DEFAULT_NMI_GAP    = 16;

    // Width needed to hold values 0..n-1, never narrower than one bit.
    function automatic int widthFor(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/segasys1_cmdfifo.sv
// Small command FIFO between main CPU and sound CPU; power-of-two depth with wrapping pointers.
// A pop and a push in the same cycle are both honoured even when full.
module segasys1_cmdfifo
    import segasys1_sndlatch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               data_i,
    output logic [7:0]               head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

    // The pop frees a slot first, which lets a push land on a full FIFO.
    assign doPop  = pop_i & ~empty_o;
    assign doPush = push_i & (~full_o | doPop);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
        if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
        unique case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/segasys1_sndlatch.sv
// Sound-command latch: queues main-CPU sound writes, NMI-signals each one to the sound CPU
// and produces the sound CPU's periodic timer IRQ.
module segasys1_sndlatch
    import segasys1_sndlatch_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int IRQ_PERIOD = DEFAULT_IRQ_PERIOD,
    parameter int NMI_GAP    = DEFAULT_NMI_GAP
) (
    input  logic       CLK48M,
    input  logic       RESET,
    input  logic       SNDRQ,
    input  logic [7:0] CPUDO,
    input  logic       SCPURD,
    input  logic       SIRQACK,
    output logic [7:0] SNDCMD,
    output logic       SNDNMI,
    output logic       SNDIRQ,
    output logic       FULL,
    output logic       OVF
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = widthFor(IRQ_PERIOD);
    localparam int GAP_W = widthFor(NMI_GAP);

    logic             rqPrev_q, rdPrev_q, ackPrev_q;
    logic             pushPulse, popPulse, ackPulse;
    logic [7:0]       fifoHead;
    logic             fifoEmpty, fifoFull;
    logic [CNT_W-1:0] fifoCount;
    logic             pending;
    logic [7:0]       lastCmd_q;
    logic             ovf_q;
    nmiState_e        state_q, state_d;
    logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             irq_q, irq_d;
    logic             tmrWrap;

    // Popping at the falling edge of the read keeps the byte stable while it is being read.
    assign pushPulse = SNDRQ & ~rqPrev_q;
    assign popPulse  = ~SCPURD & rdPrev_q & ~fifoEmpty;
    assign ackPulse  = SIRQACK & ~ackPrev_q;
    assign pending   = (fifoCount != '0);

    segasys1_cmdfifo #(
        .DEPTH(DEPTH)
    ) u_cmdfifo (
        .clk     (CLK48M),
        .reset   (RESET),
        .push_i  (pushPulse),
        .pop_i   (popPulse),
        .data_i  (CPUDO),
        .head_o  (fifoHead),
        .empty_o (fifoEmpty),
        .full_o  (fifoFull),
        .count_o (fifoCount)
    );

    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            rqPrev_q  <= 1'b0;
            rdPrev_q  <= 1'b0;
            ackPrev_q <= 1'b0;
            lastCmd_q <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            rqPrev_q  <= SNDRQ;
            rdPrev_q  <= SCPURD;
            ackPrev_q <= SIRQACK;
            if (popPulse) lastCmd_q <= fifoHead;
            if (pushPulse & fifoFull & ~popPulse) ovf_q <= 1'b1;
        end
    end

    assign SNDCMD = fifoEmpty ? lastCmd_q : fifoHead;
    assign FULL   = fifoFull;
    assign OVF    = ovf_q;

    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            gapCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            gapCnt_q <= gapCnt_d;
        end
    end

    // The gap state keeps NMI low long enough for the sound CPU to see a fresh edge.
    always_comb begin
        state_d  = state_q;
        gapCnt_d = gapCnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pending) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (SCPURD) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (popPulse) begin
                    state_d  = ST_GAP;
                    gapCnt_d = GAP_W'(NMI_GAP - 1);
                end
            end
            ST_GAP: begin
                if (gapCnt_q == '0) state_d = pending ? ST_ASSERT : ST_IDLE;
                else                gapCnt_d = gapCnt_q - GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        SNDNMI = (state_q == ST_ASSERT) || (state_q == ST_WAIT);
    end

    // A wrap beats a coincident acknowledge so no timer tick is ever lost.
    assign tmrWrap = (tmr_q == TMR_W'(IRQ_PERIOD - 1));

    always_comb begin
        tmr_d = tmrWrap ? '0 : tmr_q + TMR_W'(1);
        irq_d = irq_q;
        if (ackPulse) irq_d = 1'b0;
        if (tmrWrap)  irq_d = 1'b1;
    end

    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            tmr_q <= '0;
            irq_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            irq_q <= irq_d;
        end
    end

    assign SNDIRQ = irq_q;

endmodule

// File: tb/tb_segasys1_sndlatch.sv
// Bench for segasys1_sndlatch: a queue model of the command FIFO feeds a scoreboard that a
// monitor drains on every NMI rise, alongside directed latency, timer and collision checks.
module tb_segasys1_sndlatch;

    localparam int DEPTH = 4;
    localparam int PER   = 300;
    localparam int GAP   = 16;

    logic       clk     = 1'b0;
    logic       RESET   = 1'b1;
    logic       SNDRQ   = 1'b0;
    logic [7:0] CPUDO   = 8'h00;
    logic       SCPURD  = 1'b0;
    logic       SIRQACK = 1'b0;
    logic [7:0] SNDCMD;
    logic       SNDNMI;
    logic       SNDIRQ;
    logic       FULL;
    logic       OVF;

    int errors = 0;
    int checks = 0;

    logic [7:0] expQ[$];
    logic [7:0] sbQ[$];
    bit         modelOvf = 1'b0;
    logic [7:0] lastByte = 8'h00;

    bit prevNmi = 1'b0;
    bit hadFall = 1'b0;
    int lowCnt  = 0;

    always #5 clk = ~clk;

    segasys1_sndlatch #(
        .DEPTH(DEPTH),
        .IRQ_PERIOD(PER),
        .NMI_GAP(GAP)
    ) dut (
        .CLK48M  (clk),
        .RESET   (RESET),
        .SNDRQ   (SNDRQ),
        .CPUDO   (CPUDO),
        .SCPURD  (SCPURD),
        .SIRQACK (SIRQACK),
        .SNDCMD  (SNDCMD),
        .SNDNMI  (SNDNMI),
        .SNDIRQ  (SNDIRQ),
        .FULL    (FULL),
        .OVF     (OVF)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Model of the main CPU write: the queue accepts while space remains, otherwise flags a drop.
    task automatic modelPush(input logic [7:0] b);
        if (expQ.size() < DEPTH) begin
            expQ.push_back(b);
            sbQ.push_back(b);
        end else begin
            modelOvf = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int hold, input bit checkLatency);
        @(negedge clk);
        SNDRQ = 1'b1;
        CPUDO = b;
        modelPush(b);
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (checkLatency && i == 1) begin
                checkOutput("push_sndcmd_t1", SNDCMD, b);
                checkOutput("push_nmi_low_t1", SNDNMI, 1'b0);
            end
            if (checkLatency && i == 2) checkOutput("push_nmi_high_t2", SNDNMI, 1'b1);
        end
        SNDRQ = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitNmi(output bit ok);
        int n = 0;
        while (SNDNMI !== 1'b1 && n < GAP * 4) begin
            @(negedge clk);
            n++;
        end
        ok = (SNDNMI === 1'b1);
        if (!ok) begin
            errors++;
            checks++;
            $display("[TB] FAIL nmi_wait_timeout: SNDNMI=%b, expected 1", SNDNMI);
        end
    endtask

    task automatic readCmd();
        bit ok;
        logic [7:0] headByte;
        waitNmi(ok);
        if (!ok || expQ.size() == 0) return;
        headByte = expQ[0];
        SCPURD = 1'b1;
        @(negedge clk);
        checkOutput("read_data", SNDCMD, headByte);
        @(negedge clk);
        SCPURD = 1'b0;
        @(negedge clk);
        void'(expQ.pop_front());
        lastByte = headByte;
        checkOutput("pop_nmi_low", SNDNMI, 1'b0);
        checkOutput("pop_sndcmd", SNDCMD, (expQ.size() != 0) ? expQ[0] : lastByte);
    endtask

    task automatic doReset(input int cycles);
        RESET   = 1'b1;
        SNDRQ   = 1'b0;
        SCPURD  = 1'b0;
        SIRQACK = 1'b0;
        repeat (cycles) @(negedge clk);
        checkOutput("reset_sndcmd", SNDCMD, 8'h00);
        checkOutput("reset_nmi", SNDNMI, 1'b0);
        checkOutput("reset_irq", SNDIRQ, 1'b0);
        checkOutput("reset_full", FULL, 1'b0);
        checkOutput("reset_ovf", OVF, 1'b0);
        expQ.delete();
        sbQ.delete();
        modelOvf = 1'b0;
        lastByte = 8'h00;
        RESET    = 1'b0;
    endtask

    // Monitor: every NMI rise must present the next scoreboard byte after a long enough low gap.
    always @(posedge clk) begin
        #2;
        if (RESET) begin
            prevNmi = 1'b0;
            hadFall = 1'b0;
            lowCnt  = 0;
        end else begin
            if (SNDNMI && !prevNmi) begin
                if (sbQ.size() == 0) begin
                    errors++;
                    checks++;
                    $display("[TB] FAIL nmi_unexpected: SNDNMI rose with SNDCMD=%0h and nothing expected", SNDCMD);
                end else begin
                    checkOutput("nmi_head", SNDCMD, sbQ.pop_front());
                end
                if (hadFall) begin
                    checks++;
                    if (lowCnt < GAP) begin
                        errors++;
                        $display("[TB] FAIL nmi_gap: low for %0d cycles, expected at least %0d", lowCnt, GAP);
                    end
                end
            end else if (!SNDNMI && prevNmi) begin
                hadFall = 1'b1;
                lowCnt  = 1;
            end else if (!SNDNMI) begin
                lowCnt++;
            end
            prevNmi = SNDNMI;
        end
    end

    initial begin
        bit ok;
        logic [7:0] b;

        // Reset release, then the timer's first tick and acknowledge behaviour.
        doReset(3);
        repeat (PER - 1) @(negedge clk);
        checkOutput("irq_before_period", SNDIRQ, 1'b0);
        @(negedge clk);
        checkOutput("irq_at_period", SNDIRQ, 1'b1);
        SIRQACK = 1'b1;
        @(negedge clk);
        SIRQACK = 1'b0;
        checkOutput("irq_acked", SNDIRQ, 1'b0);
        repeat (PER - 2) @(negedge clk);
        checkOutput("irq_before_wrap2", SNDIRQ, 1'b0);
        SIRQACK = 1'b1;
        @(negedge clk);
        SIRQACK = 1'b0;
        checkOutput("irq_wrap_ack_collision", SNDIRQ, 1'b1);
        @(negedge clk);
        SIRQACK = 1'b1;
        @(negedge clk);
        SIRQACK = 1'b0;
        checkOutput("irq_acked2", SNDIRQ, 1'b0);

        // One long write strobe yields exactly one command.
        applyStimulus(8'h5A, 20, 1'b1);
        readCmd();
        repeat (GAP + 4) @(negedge clk);
        checkOutput("single_nmi_idle", SNDNMI, 1'b0);
        checkOutput("single_sndcmd_held", SNDCMD, 8'h5A);
        checkOutput("single_not_full", FULL, 1'b0);

        // Back-to-back commands drain in order.
        applyStimulus(8'h11, 1, 1'b0);
        applyStimulus(8'h22, 1, 1'b0);
        applyStimulus(8'h33, 1, 1'b0);
        repeat (3) readCmd();

        // Overflow: the fifth byte is dropped.
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1, 1'b0);
        checkOutput("ovf_full", FULL, 1'b1);
        checkOutput("ovf_flag", OVF, modelOvf);
        repeat (4) readCmd();
        checkOutput("ovf_sticky", OVF, 1'b1);

        // Reset while a command is queued and the NMI gap is running.
        applyStimulus(8'hC1, 1, 1'b0);
        applyStimulus(8'hC2, 1, 1'b0);
        readCmd();
        doReset(1);
        repeat (2) @(negedge clk);

        // Push and pop in the same cycle on a full FIFO.
        for (int i = 1; i <= 4; i++) applyStimulus(8'hA0 + 8'(i), 1, 1'b0);
        checkOutput("coll_full_before", FULL, 1'b1);
        waitNmi(ok);
        SCPURD = 1'b1;
        @(negedge clk);
        SCPURD = 1'b0;
        SNDRQ  = 1'b1;
        CPUDO  = 8'hAA;
        lastByte = expQ.pop_front();
        modelPush(8'hAA);
        @(negedge clk);
        SNDRQ = 1'b0;
        checkOutput("coll_full_after", FULL, 1'b1);
        checkOutput("coll_no_ovf", OVF, 1'b0);
        checkOutput("coll_sndcmd", SNDCMD, expQ[0]);
        checkOutput("coll_nmi_low", SNDNMI, 1'b0);
        repeat (4) readCmd();

        // Randomised mix of writes and reads against the queue model.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) != 0 || expQ.size() == 0) begin
                b = 8'($urandom);
                applyStimulus(b, $urandom_range(1, 3), 1'b0);
            end else begin
                readCmd();
            end
            checkOutput("rand_full", FULL, (expQ.size() == DEPTH));
        end
        while (expQ.size() != 0) readCmd();
        checkOutput("rand_ovf", OVF, modelOvf);
        repeat (GAP + 4) @(negedge clk);
        checkOutput("final_nmi_idle", SNDNMI, 1'b0);
        checkOutput("scoreboard_drained", sbQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
